// File: rtl/rr_arbiter_if.sv
// rtl/rr_arbiter_if.sv - request/grant bundle between requesters and the arbiter
//
// Purpose: carries the N-bit request and grant vectors as one port.
// Signals:
//   REQ  N  request vector, bit i = requester i wants the resource
//   GNT  N  grant vector, one-hot or zero
// Modports:
//   master  requester side: drives REQ, observes GNT
//   slave   arbiter side: observes REQ, drives GNT
interface rr_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] REQ;
  logic [N-1:0] GNT;

  modport master (output REQ, input GNT);
  modport slave  (input REQ, output GNT);
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - registered round-robin arbiter
//
// Purpose: N requesters share one resource. One registered, one-hot (or zero)
// grant per clock; the most recently granted requester drops to lowest priority.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    rr_arbiter_if slave modport (REQ in, GNT out)
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_arbiter_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] last_q, last_d;

  logic [IW-1:0] win;
  logic [IW-1:0] idx;
  logic          found;
  int            sum;

  // Circular search starting just after the last winner; offset N lands back
  // on the last winner itself so a sole continuous requester is re-granted.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    sum   = 0;
    for (int off = 1; off <= N; off++) begin
      sum = (int'(last_q) + off) % N;
      idx = IW'(sum);
      if (!found && bus.REQ[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    gnt_d  = '0;
    last_d = last_q;
    if (found) begin
      gnt_d[win] = 1'b1;
      last_d     = win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= '0;
      last_q <= IW'(N - 1);
    end else begin
      gnt_q  <= gnt_d;
      last_q <= last_d;
    end
  end

  assign bus.GNT = gnt_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - self-checking bench for rr_arbiter
module tb_rr_arbiter;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  bit   cmp_en;

  rr_arbiter_if #(.N(N)) bus ();

  rr_arbiter #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: winner is the set request nearest after the last winner
  // in circular distance; nothing requested leaves the last winner alone.
  int           m_last;
  logic [N-1:0] m_gnt;
  logic [N-1:0] m_prev_req;

  function automatic int pick(input logic [N-1:0] r, input int last);
    int best;
    int w;
    int d;
    best = N;
    w    = -1;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        d = (i - last - 1 + 2 * N) % N;
        if (d < best) begin
          best = d;
          w    = i;
        end
      end
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m_last     = N - 1;
      m_gnt      = '0;
      m_prev_req = '0;
    end else begin
      w          = pick(bus.REQ, m_last);
      m_prev_req = bus.REQ;
      m_gnt      = '0;
      if (w >= 0) begin
        m_gnt[w] = 1'b1;
        m_last   = w;
      end
    end
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, plus the structural invariants.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_cmp", bus.GNT, m_gnt);
      tests++;
      if (!$onehot0(bus.GNT)) begin
        fails++;
        $display("FAIL onehot: got %b, expected at most one bit set", bus.GNT);
      end
      tests++;
      if ((bus.GNT & ~m_prev_req) != '0) begin
        fails++;
        $display("FAIL gnt_without_req: got %b, expected subset of %b", bus.GNT, m_prev_req);
      end
    end
  end

  // One edge per step: REQ is driven 1 time unit after an edge and sampled on the next.
  task automatic step(input string name, input logic [N-1:0] r, input logic [N-1:0] exp);
    bus.REQ = r;
    @(posedge clk);
    #1;
    check({name, "_dut"}, bus.GNT, exp);
    check({name, "_model"}, m_gnt, exp);
  endtask

  task automatic async_reset_pulse(input string name);
    #2 rst_n = 1'b0;
    #1 check(name, bus.GNT, 4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    clk     = 1'b0;
    rst_n   = 1'b0;
    bus.REQ = '0;
    tests   = 0;
    fails   = 0;
    cmp_en  = 1'b1;

    #1 check("reset_gnt", bus.GNT, 4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    step("single_0", 4'b1000, 4'b1000);
    step("single_1", 4'b1000, 4'b1000);
    step("single_2", 4'b1000, 4'b1000);

    step("wrap_0", 4'b1010, 4'b0010);
    step("wrap_1", 4'b0010, 4'b0010);
    step("wrap_2", 4'b0110, 4'b0100);
    step("wrap_3", 4'b1110, 4'b1000);

    step("pre_midop", 4'b0010, 4'b0010);
    async_reset_pulse("midop_reset");

    step("full_0", 4'b1111, 4'b0001);
    step("full_1", 4'b1111, 4'b0010);
    step("full_2", 4'b1111, 4'b0100);
    step("full_3", 4'b1111, 4'b1000);
    step("full_4", 4'b1111, 4'b0001);

    step("pre_idle_0", 4'b1111, 4'b0010);
    step("pre_idle_1", 4'b1111, 4'b0100);
    step("idle", 4'b0000, 4'b0000);
    step("after_idle", 4'b1111, 4'b1000);

    bus.REQ = 4'b0000;
    async_reset_pulse("idle_reset");
    step("post_reset_1111", 4'b1111, 4'b0001);

    for (int i = 0; i < 600; i++) begin
      if (i % 3 == 0)
        bus.REQ = N'($urandom_range(0, (1 << N) - 1));
      else if (i % 3 == 1)
        bus.REQ = N'($urandom & $urandom);
      else if ($urandom_range(0, 3) == 0)
        bus.REQ = '1;
      if (i % 97 == 50) begin
        async_reset_pulse("rand_reset");
      end else begin
        @(posedge clk);
        #1;
      end
    end

    bus.REQ = '0;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
